// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built around one full_adder_ha cell.
// Operands are consumed LSB first, one bit per cycle, with the carry held in a register
// between bits. A start in IDLE or DONE loads a new add. A start during RUN is ignored.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit per cycle through the adder cell
// DONE  | done pulse; sum/cout valid; start here begins the next add at once

module full_adder_ha (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    // Two half adders plus an OR for the carry.
    logic s1;
    logic c1;
    logic c2;

    assign s1 = x ^ y;
    assign c1 = x & y;
    assign s  = s1 ^ ci;
    assign c2 = s1 & ci;
    assign co = c1 | c2;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cell_s;
    logic             cell_co;

    full_adder_ha u_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    // Sequencer: loads operands on an accepted start, steps one bit per RUN cycle,
    // and publishes sum/cout (and ovf) only on the RUN->DONE transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= RUN;
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        sum_sr <= '0;
                        busy   <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= {cell_s, sum_sr[WIDTH-1:1]};
                    carry  <= cell_co;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= {cell_s, sum_sr[WIDTH-1:1]};
                        cout  <= cell_co;
`ifdef SERIAL_ADD_OVF_EN
                        // carry still holds the carry into the MSB on the last bit
                        ovf   <= carry ^ cell_co;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8): directed vectors plus a reference-model
// sweep, checked through a scoreboard queue drained by a done-driven monitor.
module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .cout  (cout),
        .ovf   (ovf)
`else
        .cout  (cout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
        int               t;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result and compares it.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_done_excl", {31'b0, busy & done}, 32'd0);
            if (done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending add");
                end else begin
                    mon_e = sb.pop_front();
                    chk("sum", {24'b0, sum}, {24'b0, mon_e.s});
                    chk("cout", {31'b0, cout}, {31'b0, mon_e.c});
`ifdef SERIAL_ADD_OVF_EN
                    chk("ovf", {31'b0, ovf}, {31'b0, mon_e.o});
`endif
                    chk("latency", cyc + 1 - mon_e.t, WIDTH + 1);
                end
            end
        end
    end

    // Call right after a negedge with the DUT in IDLE or DONE.
    task automatic do_add(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.s = es;
        e.c = ec;
        e.o = eo;
        e.t = cyc;
        sb.push_back(e);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'($urandom);
    endtask

    // Returns just after the negedge on which done is seen.
    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_sum"}, {24'b0, sum}, 32'd0);
        chk({tag, "_cout"}, {31'b0, cout}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, "_ovf"}, {31'b0, ovf}, 32'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc0;
        logic [7:0] av, bv, es;
        logic cv, ec, eo;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        do_add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        wait_done();
        @(negedge clk);
        do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        wait_done();
        @(negedge clk);
        do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        // Back-to-back: second start is held in the DONE cycle
        do_add(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        wait_done();
        do_add(8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0);
        wait_done();
        repeat (3) @(negedge clk);
        chk("sum_hold", {24'b0, sum}, 32'h0000_00FF);

        // Start in the 3rd busy cycle must be ignored
        dc0 = done_cnt;
        do_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        repeat (15) @(negedge clk);
        chk("single_done", done_cnt - dc0, 32'd1);

        // Reset in the 4th busy cycle aborts the add
        do_add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        chk_zero("midrst");
        dc0 = done_cnt;
        repeat (20) @(negedge clk);
        chk("no_done_after_rst", done_cnt - dc0, 32'd0);
        do_add(8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1, 1'b0);
        wait_done();
        @(negedge clk);

        // Reference-model sweep, mixing idle gaps and back-to-back starts
        for (int n = 0; n < 1000; n++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            cv = 1'($urandom);
            {ec, es} = {1'b0, av} + {1'b0, bv} + {8'b0, cv};
            eo = (av[7] == bv[7]) && (es[7] != av[7]);
            do_add(av, bv, cv, es, ec, eo);
            wait_done();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
